// File: rtl/i2s_frame_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2s_frame_ctrl : I2S bck/lrck generation and 64-bit stereo frame sequencing
// Rev 1.0
// ---------------------------------------------------------------------------
module i2s_frame_ctrl #(
  parameter int MCK_PER_BCK = 4,
  parameter int SAMPLE_BITS = 24
) (
  input  logic                   mck,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   sdin,
  output logic                   bck,
  output logic                   lrck,
  output logic                   sdout,
  output logic [SAMPLE_BITS-1:0] rx_left,
  output logic [SAMPLE_BITS-1:0] rx_right,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   rx_overrun,
  input  logic [SAMPLE_BITS-1:0] tx_left,
  input  logic [SAMPLE_BITS-1:0] tx_right,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   tx_underrun
);

  localparam int            CW          = $clog2(MCK_PER_BCK);
  localparam logic [CW-1:0] CNT_LAST    = CW'(MCK_PER_BCK - 1);
  localparam logic [CW-1:0] CNT_HALF    = CW'(MCK_PER_BCK / 2);
  localparam logic [CW-1:0] CNT_RISE    = CW'(MCK_PER_BCK / 2 - 1);
  localparam logic [4:0]    SLOT_LAST   = 5'(SAMPLE_BITS);
  localparam logic [5:0]    RX_DONE_BIT = 6'(32 + SAMPLE_BITS);

  logic [CW-1:0]          mck_cnt, mck_cnt_nxt;
  logic [5:0]             bit_cnt, bit_cnt_nxt;
  logic                   rise_evt, fall_evt, frame_start;
  logic [4:0]             slot_cur, slot_nxt, tx_idx;
  logic                   rx_bit_en, tx_bit;
  logic [31:0]            tx_word;

  logic [SAMPLE_BITS-1:0] rx_sh_l, rx_sh_r;
  logic                   cap_done;
  logic [SAMPLE_BITS-1:0] hold_l, hold_r;
  logic                   hold_full;
  logic [SAMPLE_BITS-1:0] tx_sh_l, tx_sh_r;

  always_comb begin
    rise_evt    = en && (mck_cnt == CNT_RISE);
    fall_evt    = en && (mck_cnt == CNT_LAST);
    frame_start = fall_evt && (bit_cnt == 6'd63);
    mck_cnt_nxt = '0;
    bit_cnt_nxt = '0;
    if (en) begin
      mck_cnt_nxt = fall_evt ? '0 : mck_cnt + CW'(1);
      bit_cnt_nxt = fall_evt ? bit_cnt + 6'd1 : bit_cnt;
    end
  end

  // Data occupies slot bits 1..SAMPLE_BITS; bit 0 is the I2S delay bit.
  always_comb begin
    slot_cur  = bit_cnt[4:0];
    slot_nxt  = bit_cnt_nxt[4:0];
    rx_bit_en = (slot_cur != 5'd0) && (slot_cur <= SLOT_LAST);
    tx_word   = 32'(bit_cnt_nxt[5] ? tx_sh_r : tx_sh_l);
    tx_idx    = SLOT_LAST - slot_nxt;
    tx_bit    = 1'b0;
    if ((slot_nxt != 5'd0) && (slot_nxt <= SLOT_LAST)) begin
      tx_bit = tx_word[tx_idx];
    end
  end

  always_ff @(posedge mck or negedge reset_n) begin
    if (!reset_n) begin
      mck_cnt <= '0;
      bit_cnt <= '0;
      bck     <= 1'b0;
      lrck    <= 1'b0;
      sdout   <= 1'b0;
    end else begin
      mck_cnt <= mck_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      bck     <= en && (mck_cnt_nxt >= CNT_HALF);
      lrck    <= bit_cnt_nxt[5];
      if (!en) begin
        sdout <= 1'b0;
      end else if (fall_evt) begin
        sdout <= tx_bit;
      end
    end
  end

  always_ff @(posedge mck or negedge reset_n) begin
    if (!reset_n) begin
      rx_sh_l  <= '0;
      rx_sh_r  <= '0;
      cap_done <= 1'b0;
    end else begin
      cap_done <= rise_evt && (bit_cnt == RX_DONE_BIT);
      if (!en) begin
        rx_sh_l <= '0;
        rx_sh_r <= '0;
      end else if (rise_evt && rx_bit_en) begin
        if (bit_cnt[5]) begin
          rx_sh_r <= {rx_sh_r[SAMPLE_BITS-2:0], sdin};
        end else begin
          rx_sh_l <= {rx_sh_l[SAMPLE_BITS-2:0], sdin};
        end
      end
    end
  end

  // A completed frame always overwrites; an unconsumed one is flagged.
  always_ff @(posedge mck or negedge reset_n) begin
    if (!reset_n) begin
      rx_left    <= '0;
      rx_right   <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= cap_done && rx_valid && !rx_ready;
      if (cap_done) begin
        rx_left  <= rx_sh_l;
        rx_right <= rx_sh_r;
        rx_valid <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // A load coinciding with frame start lands in the holding register only.
  always_ff @(posedge mck or negedge reset_n) begin
    if (!reset_n) begin
      hold_l      <= '0;
      hold_r      <= '0;
      hold_full   <= 1'b0;
      tx_sh_l     <= '0;
      tx_sh_r     <= '0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= frame_start && !hold_full;
      if (tx_valid && !hold_full) begin
        hold_l    <= tx_left;
        hold_r    <= tx_right;
        hold_full <= 1'b1;
      end else if (frame_start) begin
        hold_full <= 1'b0;
      end
      if (!en) begin
        tx_sh_l <= '0;
        tx_sh_r <= '0;
      end else if (frame_start) begin
        tx_sh_l <= hold_full ? hold_l : '0;
        tx_sh_r <= hold_full ? hold_r : '0;
      end
    end
  end

  assign tx_ready = !hold_full;

endmodule
`default_nettype wire

// File: tb/tb_i2s_frame_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_i2s_frame_ctrl : frame-level directed checks with a bench-side codec
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_i2s_frame_ctrl;

  logic        mck = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        sdin = 1'b0;
  logic        bck, lrck, sdout;
  logic [23:0] rx_left, rx_right;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        rx_overrun;
  logic [23:0] tx_left = '0, tx_right = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, tx_underrun;

  int n_cmp  = 0;
  int n_fail = 0;

  i2s_frame_ctrl #(.MCK_PER_BCK(4), .SAMPLE_BITS(24)) dut (
    .mck(mck), .reset_n(reset_n), .en(en), .sdin(sdin),
    .bck(bck), .lrck(lrck), .sdout(sdout),
    .rx_left(rx_left), .rx_right(rx_right), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_overrun(rx_overrun),
    .tx_left(tx_left), .tx_right(tx_right), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_underrun(tx_underrun)
  );

  always #5 mck = ~mck;

  typedef struct {
    logic [23:0] in_l, in_r;
    bit          rdy, offer;
    int          offer_j;
    logic [23:0] tx_l, tx_r;
    int          e_rxv;
    logic [23:0] e_rx_l, e_rx_r;
    int          e_ovr, e_und;
    logic [23:0] e_out_l, e_out_r;
    int          e_rdy_low;
  } vec_t;

  typedef struct {
    logic [23:0] rx_l, rx_r, out_l, out_r;
    int          rxv, ovr, und, rdy_low, terr;
  } res_t;

  vec_t vt[6];
  res_t r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_bck"}, 32'(bck), 0);
    chk({tag, "_lrck"}, 32'(lrck), 0);
    chk({tag, "_sdout"}, 32'(sdout), 0);
    chk({tag, "_rx_left"}, 32'(rx_left), 0);
    chk({tag, "_rx_right"}, 32'(rx_right), 0);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 0);
    chk({tag, "_rx_overrun"}, 32'(rx_overrun), 0);
    chk({tag, "_tx_underrun"}, 32'(tx_underrun), 0);
    chk({tag, "_tx_ready"}, 32'(tx_ready), 1);
  endtask

  // Iteration j observes the interval after the j-th enabled mck edge of the frame.
  task automatic run_seq(input int len, input logic [23:0] in_l, input logic [23:0] in_r,
                         input bit rdy, input bit offer, input int offer_j,
                         input logic [23:0] d_l, input logic [23:0] d_r, output res_t res);
    int b, s;
    res = '{default: 0};
    for (int j = 0; j < len; j++) begin
      @(negedge mck);
      b = j / 4;
      s = b % 32;
      if (j == 0) rx_ready = rdy;
      if (s >= 1 && s <= 24) sdin = (b < 32) ? in_l[24-s] : in_r[24-s];
      else sdin = 1'b1;
      tx_valid = offer && (j == offer_j);
      tx_left  = d_l;
      tx_right = d_r;
      if (bck !== ((j % 4) >= 2)) res.terr++;
      if (lrck !== (b >= 32)) res.terr++;
      if (j % 4 == 2) begin
        if (s >= 1 && s <= 24) begin
          if (b < 32) res.out_l[24-s] = sdout;
          else res.out_r[24-s] = sdout;
        end else if (sdout !== 1'b0) begin
          res.terr++;
        end
      end
      if (rx_valid === 1'b1) res.rxv++;
      if (rx_overrun === 1'b1) res.ovr++;
      if (tx_underrun === 1'b1) res.und++;
      if (tx_ready === 1'b0) res.rdy_low++;
      if (j == 227) begin
        res.rx_l = rx_left;
        res.rx_r = rx_right;
      end
    end
  endtask

  task automatic chk_frame(input string tag, input res_t x, input logic [23:0] e_l,
                           input logic [23:0] e_r, input int e_rxv, input int e_ovr,
                           input int e_und, input logic [23:0] eo_l, input logic [23:0] eo_r,
                           input int e_rdy_low);
    chk({tag, "_rx_left"}, 32'(x.rx_l), 32'(e_l));
    chk({tag, "_rx_right"}, 32'(x.rx_r), 32'(e_r));
    chk({tag, "_rx_valid_cycles"}, 32'(x.rxv), 32'(e_rxv));
    chk({tag, "_overrun_pulses"}, 32'(x.ovr), 32'(e_ovr));
    chk({tag, "_underrun_pulses"}, 32'(x.und), 32'(e_und));
    chk({tag, "_sdout_left"}, 32'(x.out_l), 32'(eo_l));
    chk({tag, "_sdout_right"}, 32'(x.out_r), 32'(eo_r));
    chk({tag, "_tx_ready_low_cycles"}, 32'(x.rdy_low), 32'(e_rdy_low));
    chk({tag, "_timing_errors"}, 32'(x.terr), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    //           in_l        in_r        rdy off j    tx_l        tx_r        rxv  e_rx_l      e_rx_r      ovr und e_out_l     e_out_r     rdylow
    vt[0] = '{24'h888888, 24'hF0F0F0, 1, 1, 8,   24'h123456, 24'h612345, 1,   24'h888888, 24'hF0F0F0, 0, 0, 24'h000000, 24'h000000, 247};
    vt[1] = '{24'hA5A5A5, 24'h5A5A5A, 1, 0, -1,  24'h000000, 24'h000000, 1,   24'hA5A5A5, 24'h5A5A5A, 0, 0, 24'h123456, 24'h612345, 0};
    vt[2] = '{24'h000001, 24'h800000, 1, 0, -1,  24'h000000, 24'h000000, 1,   24'h000001, 24'h800000, 0, 1, 24'h000000, 24'h000000, 0};
    vt[3] = '{24'h1F3AF0, 24'h0FFFFF, 0, 1, 255, 24'h7FFFFF, 24'h800001, 29,  24'h1F3AF0, 24'h0FFFFF, 0, 1, 24'h000000, 24'h000000, 0};
    vt[4] = '{24'h123456, 24'h654321, 0, 0, -1,  24'h000000, 24'h000000, 256, 24'h123456, 24'h654321, 1, 1, 24'h000000, 24'h000000, 256};
    vt[5] = '{24'hFFFFFF, 24'h000000, 1, 0, -1,  24'h000000, 24'h000000, 2,   24'hFFFFFF, 24'h000000, 0, 0, 24'h7FFFFF, 24'h800001, 0};

    en = 1'b1;
    repeat (3) @(posedge mck);
    #1;
    chk_reset("reset");
    reset_n = 1'b1;

    foreach (vt[i]) begin
      run_seq(256, vt[i].in_l, vt[i].in_r, vt[i].rdy, vt[i].offer, vt[i].offer_j,
              vt[i].tx_l, vt[i].tx_r, r);
      chk_frame($sformatf("frame%0d", i), r, vt[i].e_rx_l, vt[i].e_rx_r, vt[i].e_rxv,
                vt[i].e_ovr, vt[i].e_und, vt[i].e_out_l, vt[i].e_out_r, vt[i].e_rdy_low);
    end

    // Reset asserted at bit_cnt 40 with a TX frame pending.
    run_seq(162, 24'h0F1E2D, 24'h3C4B5A, 1, 1, 8, 24'hABCDEF, 24'hFEDCBA, r);
    chk("pre_reset_tx_ready", 32'(tx_ready), 0);
    chk("pre_reset_lrck", 32'(lrck), 1);
    reset_n = 1'b0;
    #1;
    chk_reset("midreset");
    @(posedge mck);
    #1 reset_n = 1'b1;
    run_seq(256, 24'h3C3C3C, 24'hC3C3C3, 1, 1, 8, 24'h0F0F0F, 24'hF0F0F0, r);
    chk_frame("post_reset", r, 24'h3C3C3C, 24'hC3C3C3, 1, 0, 0, 24'h0, 24'h0, 247);

    // en dropped mid-frame with a TX frame pending in the holding register.
    run_seq(162, 24'h111111, 24'h222222, 1, 1, 8, 24'h2468AC, 24'h13579B, r);
    en = 1'b0;
    repeat (100) @(posedge mck);
    @(negedge mck);
    chk("en_low_bck", 32'(bck), 0);
    chk("en_low_lrck", 32'(lrck), 0);
    chk("en_low_sdout", 32'(sdout), 0);
    chk("en_low_tx_ready", 32'(tx_ready), 0);
    chk("en_low_rx_left_kept", 32'(rx_left), 32'h3C3C3C);
    @(posedge mck);
    #1 en = 1'b1;
    run_seq(256, 24'h5A5A5A, 24'h00FF00, 1, 0, -1, 24'h0, 24'h0, r);
    chk_frame("en_first", r, 24'h5A5A5A, 24'h00FF00, 1, 0, 0, 24'h0, 24'h0, 256);
    run_seq(256, 24'h876543, 24'h000100, 1, 0, -1, 24'h0, 24'h0, r);
    chk_frame("en_second", r, 24'h876543, 24'h000100, 1, 0, 0, 24'h2468AC, 24'h13579B, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
